// File: rtl/reduce_sum_nbit_pkg.sv
// State encodings for the vector sum reducer.
// These are kept in one place so that the top and any future monitors agree on them.
package reduce_sum_nbit_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/adder_nbit.sv
// N-bit adder, sum modulo 2^WIDTH with the carry-out dropped; IMPL_TYPE picks the gate style.
// Latency: combinational, zero cycles.
// Backpressure: none, this is a pure datapath.
module adder_nbit #(
    parameter int WIDTH     = 32,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    generate
        if (IMPL_TYPE == 1) begin : g_ripple
            logic [WIDTH-1:0] c;
            assign c[0] = 1'b0;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                assign sum[i] = a[i] ^ b[i] ^ c[i];
                // The carry out of the MSB is never formed.
                if (i < WIDTH-1) begin : g_carry
                    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
                end
            end
        end else begin : g_behav
            assign sum = a + b;
        end
    endgenerate

endmodule

// File: rtl/reduce_sum_nbit.sv
// Accumulates a valid/ready stream of elements into one sum and element count per vector.
// Latency: the result is valid the cycle after the in_last transfer.
// Backpressure: input stalls while a result is held, and there is one bubble after each result.
module reduce_sum_nbit
    import reduce_sum_nbit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMPL_TYPE = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic [CNT_WIDTH-1:0] out_count
);

    logic [1:0]           state;
    logic [WIDTH-1:0]     acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic [WIDTH-1:0]     add_sum;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 in_xfer;
    logic                 out_xfer;

    adder_nbit #(
        .WIDTH     (WIDTH),
        .IMPL_TYPE (IMPL_TYPE)
    ) u_adder (
        .a   (acc),
        .b   (in_data),
        .sum (add_sum)
    );

    assign in_ready  = (state != ST_DONE);
    assign out_valid = (state == ST_DONE);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign out_sum   = acc;
    assign out_count = cnt;

    // The count sticks at all-ones; the sum keeps absorbing elements.
    assign cnt_inc = (&cnt) ? cnt : cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_xfer) begin
                        acc   <= in_data;
                        cnt   <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        state <= in_last ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_xfer) begin
                        acc   <= add_sum;
                        cnt   <= cnt_inc;
                        state <= in_last ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    if (out_xfer) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/reduce_sum_nbit.md
REDUCE_SUM_NBIT -- requirements
Module: reduce_sum_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 SHALL have parameter IMPL_TYPE, default 0, passed unchanged to the adder sub-module gate-style selection.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, element-count width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input element present.
REQ-007 SHALL have port in_ready  output  1  block accepts element this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  element to accumulate.
REQ-009 SHALL have port in_last  input  1  element is final of current vector.
REQ-010 SHALL have port out_valid  output  1  reduction result held.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port out_sum  output  WIDTH  sum of vector, modulo 2^WIDTH.
REQ-013 SHALL have port out_count  output  CNT_WIDTH  elements in vector, saturating.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-015 Input transfer SHALL occur when in_valid and in_ready are both high on a rising edge; output transfer when out_valid and out_ready are both high.
REQ-016 in_ready SHALL be high in IDLE and ACCUM, low in DONE; out_valid SHALL be high only in DONE.
REQ-017 IDLE, transfer, in_last=0: acc <= in_data, cnt <= 1, go ACCUM.
REQ-018 IDLE, transfer, in_last=1: acc <= in_data, cnt <= 1, go DONE (single-element vector).
REQ-019 ACCUM, transfer: acc <= acc + in_data, cnt <= cnt + 1; go DONE if in_last, else stay ACCUM.
REQ-020 Addition SHALL be modulo 2^WIDTH; carry out of MSB discarded; no overflow flag.
REQ-021 cnt SHALL saturate at 2^CNT_WIDTH-1; further elements still summed.
REQ-022 DONE SHALL hold out_sum=acc, out_count=cnt stable until output transfer; out_sum/out_count outside DONE SHALL read last registered values.
REQ-023 DONE, output transfer: go IDLE; the next element is accepted no earlier than the following cycle (one bubble per vector).
REQ-024 Latency: out_valid asserts the cycle after the in_last transfer.
REQ-025 in_valid low in ACCUM SHALL hold acc/cnt unchanged (gaps allowed, no timeout).
REQ-026 in_data/in_last SHALL be ignored when no input transfer occurs.
REQ-027 Single registered adder path: one addition per cycle, sustained throughput one element/cycle within a vector.

Reset
REQ-028 rst high SHALL asynchronously force state=IDLE, acc=0, cnt=0, so in_ready=1, out_valid=0, out_sum=0, out_count=0.
REQ-029 rst asserted mid-vector or in DONE SHALL discard the partial/pending result; no output transfer for it.
REQ-030 First accepting edge SHALL be the first rising clk edge after rst deasserts.

Structure
REQ-031 State encoding constants (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) SHALL live in the shared submodules constants package/include, not locally.
REQ-032 The adder SHALL be one instance of adder_nbit (WIDTH, IMPL_TYPE forwarded), A=acc, B=in_data; no behavioural "+" for acc.
REQ-033 Count increment MAY be behavioural; no other sub-modules.

Verification
REQ-034 WIDTH=8: vector 3,5,7 (last on 7), out_ready=1 -> out_valid one cycle after 7 accepted, out_sum=15, out_count=3, then IDLE.
REQ-035 WIDTH=8: 200,100 last -> out_sum=44 (wrap), out_count=2.
REQ-036 Single element 0xA5 with in_last=1 -> DONE next cycle, out_sum=0xA5, out_count=1.
REQ-037 Result held with out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0, out_sum stable, no element consumed; release -> next vector starts after one bubble.
REQ-038 rst pulsed after 2 of 4 elements, mid-cycle -> immediate out_valid=0, in_ready=1, sums 0; next vector 1,1 last -> out_sum=2.
REQ-039 CNT_WIDTH=2, 5 elements of 1 -> out_sum=5, out_count=3 (saturated).
